miriscv_rf_dp: RTL and testbench

Parametrised two-write/two-read register file for the miriscv core. It succeeds the single-write RF:
- data width and depth are configurable;
- a second write port is added for the load/ALU dual-retire path;
- register x0 is hardwired to zero;
- the array is zeroed by a sequential clear engine instead of a single-cycle wipe.

It sits between decode (read addresses) and writeback (write ports).

---
 rtl/miriscv_rf_dp.sv | 183 ++++++++++++++++++
 tb/tb_miriscv_rf_dp.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/miriscv_rf_dp.sv
// -----------------------------------------------------------------------------
// miriscv_rf_dp
// Two-write / two-read register file for the miriscv core.
//   - DEPTH = 2**ADDR_W registers of DATA_W bits; x0 always reads zero.
//   - Two write ports (load / ALU dual retire); port 2 wins on a same-address
//     collision, and wr_conflict_o pulses for one cycle afterwards.
//   - The array is zeroed by a sequential clear engine (one entry per cycle,
//     entries 1..DEPTH-1) after reset and on request via clr_i.
//
// Ports:
//   clk_i          clock, rising edge
//   rst_n_i        asynchronous active-low reset (starts a clear sweep)
//   clr_i          request a full clear (honoured only when idle)
//   busy_o         clear sweep in progress (reads give 0, writes dropped)
//   addr1_i/rd1_o  read port 1 (combinational)
//   addr2_i/rd2_o  read port 2 (combinational)
//   wa1_i/wd1_i/we1_i  write port 1
//   wa2_i/wd2_i/we2_i  write port 2
//   wr_conflict_o  registered: both ports wrote the same nonzero address
//                  in the previous cycle
//
// Optional feature macro: MIRISCV_RF_BYPASS_EN
//   When defined, a read that matches a committing write in the same cycle
//   returns the write data combinationally (port 2 has precedence).
//   When undefined, reads return the pre-edge array contents.
// -----------------------------------------------------------------------------
module miriscv_rf_dp #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              clr_i,
   output logic              busy_o,
   input  logic [ADDR_W-1:0] addr1_i,
   input  logic [ADDR_W-1:0] addr2_i,
   output logic [DATA_W-1:0] rd1_o,
   output logic [DATA_W-1:0] rd2_o,
   input  logic [ADDR_W-1:0] wa1_i,
   input  logic [DATA_W-1:0] wd1_i,
   input  logic              we1_i,
   input  logic [ADDR_W-1:0] wa2_i,
   input  logic [DATA_W-1:0] wd2_i,
   input  logic              we2_i,
   output logic              wr_conflict_o
);

   localparam int DEPTH = 2 ** ADDR_W;

   localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
   localparam logic [ADDR_W-1:0] PTR_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};
   // Entry 0 is never stored meaningfully, so the sweep starts at 1.
   localparam logic [ADDR_W-1:0] PTR_FIRST = PTR_ONE;
   localparam logic [ADDR_W-1:0] PTR_LAST  = {ADDR_W{1'b1}};
   localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_e;

   state_e              state_r;
   state_e              state_s;
   logic [ADDR_W-1:0]   ptr_r;
   logic [ADDR_W-1:0]   ptr_s;
   logic [DATA_W-1:0]   mem_r [DEPTH];
   logic                busy_s;
   logic                we1_eff_s;
   logic                we2_eff_s;
   logic                conflict_s;
   logic                wr_conflict_r;

   assign busy_s        = (state_r == CLEAR);
   assign busy_o        = busy_s;
   assign wr_conflict_o = wr_conflict_r;

   // Effective write enables: idle only, address 0 is dropped.
   assign we1_eff_s  = we1_i & ~busy_s & (wa1_i != ADDR_ZERO);
   assign we2_eff_s  = we2_i & ~busy_s & (wa2_i != ADDR_ZERO);
   assign conflict_s = we1_eff_s & we2_eff_s & (wa1_i == wa2_i);

   // Clear-engine state and pointer register; reset launches a sweep.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_r <= CLEAR;
         ptr_r   <= PTR_FIRST;
      end else begin
         state_r <= state_s;
         ptr_r   <= ptr_s;
      end
   end

   // Clear-engine next state: idle waits for clr_i, sweep ends on the last entry.
   always_comb begin
      state_s = state_r;
      ptr_s   = ptr_r;
      case (state_r)
         IDLE: begin
            if (clr_i) begin
               state_s = CLEAR;
               ptr_s   = PTR_FIRST;
            end else begin
               state_s = IDLE;
               ptr_s   = ptr_r;
            end
         end
         CLEAR: begin
            if (ptr_r == PTR_LAST) begin
               state_s = IDLE;
               ptr_s   = PTR_FIRST;
            end else begin
               state_s = CLEAR;
               ptr_s   = ptr_r + PTR_ONE;
            end
         end
         default: begin
            state_s = CLEAR;
            ptr_s   = PTR_FIRST;
         end
      endcase
   end

   // Collision flag: one-cycle pulse after both ports hit the same address.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         wr_conflict_r <= 1'b0;
      end else begin
         wr_conflict_r <= conflict_s;
      end
   end

   // Storage array: sweep writes zero, otherwise port 1 then port 2 so that
   // port 2 overrides on a same-address collision. Not reset; the sweep clears it.
   always_ff @(posedge clk_i) begin
      if (busy_s) begin
         mem_r[ptr_r] <= DATA_ZERO;
      end else begin
         if (we1_eff_s) begin
            mem_r[wa1_i] <= wd1_i;
         end
         if (we2_eff_s) begin
            mem_r[wa2_i] <= wd2_i;
         end
      end
   end

   // Read port 1: zero for x0 or during a sweep, optional same-cycle bypass.
   always_comb begin
      rd1_o = DATA_ZERO;
      if (busy_s || (addr1_i == ADDR_ZERO)) begin
         rd1_o = DATA_ZERO;
      end
`ifdef MIRISCV_RF_BYPASS_EN
      else if (we2_eff_s && (wa2_i == addr1_i)) begin
         rd1_o = wd2_i;
      end else if (we1_eff_s && (wa1_i == addr1_i)) begin
         rd1_o = wd1_i;
      end
`endif
      else begin
         rd1_o = mem_r[addr1_i];
      end
   end

   // Read port 2: same rules as port 1.
   always_comb begin
      rd2_o = DATA_ZERO;
      if (busy_s || (addr2_i == ADDR_ZERO)) begin
         rd2_o = DATA_ZERO;
      end
`ifdef MIRISCV_RF_BYPASS_EN
      else if (we2_eff_s && (wa2_i == addr2_i)) begin
         rd2_o = wd2_i;
      end else if (we1_eff_s && (wa1_i == addr2_i)) begin
         rd2_o = wd1_i;
      end
`endif
      else begin
         rd2_o = mem_r[addr2_i];
      end
   end

endmodule

// File: tb/tb_miriscv_rf_dp.sv
// -----------------------------------------------------------------------------
// tb_miriscv_rf_dp
// Scoreboard bench for miriscv_rf_dp (DATA_W = 32, ADDR_W = 5).
// The driver applies inputs just after each rising edge and pushes the
// expected outputs, computed from a behavioural model (array + countdown),
// into a queue; a monitor on the falling edge pops and compares.
// -----------------------------------------------------------------------------
module tb_miriscv_rf_dp;

   localparam int DW    = 32;
   localparam int AW    = 5;
   localparam int DEPTH = 32;

   logic          clk   = 1'b0;
   logic          rst_n = 1'b0;
   logic          clr   = 1'b0;
   logic [AW-1:0] a1    = '0;
   logic [AW-1:0] a2    = '0;
   logic [AW-1:0] wa1   = '0;
   logic [AW-1:0] wa2   = '0;
   logic [DW-1:0] wd1   = '0;
   logic [DW-1:0] wd2   = '0;
   logic          we1   = 1'b0;
   logic          we2   = 1'b0;
   logic          busy;
   logic          conf;
   logic [DW-1:0] rd1;
   logic [DW-1:0] rd2;

   miriscv_rf_dp #(.DATA_W(DW), .ADDR_W(AW)) dut (
      .clk_i        (clk),
      .rst_n_i      (rst_n),
      .clr_i        (clr),
      .busy_o       (busy),
      .addr1_i      (a1),
      .addr2_i      (a2),
      .rd1_o        (rd1),
      .rd2_o        (rd2),
      .wa1_i        (wa1),
      .wd1_i        (wd1),
      .we1_i        (we1),
      .wa2_i        (wa2),
      .wd2_i        (wd2),
      .we2_i        (we2),
      .wr_conflict_o(conf)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic          busy;
      logic          conf;
      logic [DW-1:0] rd1;
      logic [DW-1:0] rd2;
      logic [AW-1:0] a1;
      logic [AW-1:0] a2;
   } exp_t;

   exp_t q[$];
   exp_t mon_e;
   int   total = 0;
   int   bad   = 0;

   // Reference model: register contents, remaining sweep cycles, pending flag.
   logic [DW-1:0] m [DEPTH];
   int            busy_cnt = DEPTH - 1;
   logic          conf_m   = 1'b0;
   bit            in_reset = 1'b0;

   function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
      if (a == 0 || busy_cnt > 0) return {DW{1'b0}};
`ifdef MIRISCV_RF_BYPASS_EN
      if (we2 && wa2 == a) return wd2;
      if (we1 && wa1 == a) return wd1;
`endif
      return m[a];
   endfunction

   task automatic zero_model();
      for (int i = 0; i < DEPTH; i++) m[i] = {DW{1'b0}};
   endtask

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // Monitor: compare every queued expectation against the DUT outputs.
   always @(negedge clk) begin
      while (q.size() > 0) begin
         mon_e = q.pop_front();
         chk("busy", {31'd0, busy}, {31'd0, mon_e.busy});
         chk("wr_conflict", {31'd0, conf}, {31'd0, mon_e.conf});
         chk($sformatf("rd1[x%0d]", mon_e.a1), rd1, mon_e.rd1);
         chk($sformatf("rd2[x%0d]", mon_e.a2), rd2, mon_e.rd2);
      end
   end

   // One cycle: queue expectation for current inputs, then advance the model.
   task automatic step();
      exp_t e;
      e.busy = (busy_cnt > 0);
      e.conf = conf_m;
      e.rd1  = model_read(a1);
      e.rd2  = model_read(a2);
      e.a1   = a1;
      e.a2   = a2;
      q.push_back(e);
      @(posedge clk);
      if (!in_reset) begin
         if (busy_cnt > 0) begin
            busy_cnt--;
            conf_m = 1'b0;
         end else begin
            conf_m = we1 && we2 && (wa1 == wa2) && (wa1 != 0);
            if (we1 && wa1 != 0) m[wa1] = wd1;
            if (we2 && wa2 != 0) m[wa2] = wd2;
            if (clr) begin
               busy_cnt = DEPTH - 1;
               zero_model();
            end
         end
      end
      #1;
   endtask

   task automatic quiet();
      we1 = 1'b0; we2 = 1'b0; clr = 1'b0;
   endtask

   task automatic do_reset();
      rst_n    = 1'b0;
      in_reset = 1'b1;
      busy_cnt = DEPTH - 1;
      conf_m   = 1'b0;
      zero_model();
      step();
      step();
      rst_n    = 1'b1;
      in_reset = 1'b0;
   endtask

   task automatic rand_inputs(input bit allow_clr);
      a1  = AW'($urandom);
      a2  = AW'($urandom);
      we1 = 1'($urandom);
      we2 = 1'($urandom);
      wa1 = AW'($urandom);
      wa2 = ($urandom_range(3) == 0) ? wa1 : AW'($urandom);
      wd1 = $urandom;
      wd2 = $urandom;
      clr = allow_clr && ($urandom_range(39) == 0);
   endtask

   task automatic read_all();
      quiet();
      for (int i = 0; i < DEPTH; i++) begin
         a1 = AW'(i);
         a2 = AW'(DEPTH - 1 - i);
         step();
      end
   endtask

   initial begin
      zero_model();
      #1;
      // Reset and initial sweep with random traffic that must be ignored.
      do_reset();
      for (int i = 0; i < DEPTH - 1; i++) begin
         rand_inputs(1'b1);
         step();
      end
      read_all();

      // Dual write then read back.
      we1 = 1'b1; wa1 = 5'd1;  wd1 = 32'h0000_0006;
      we2 = 1'b1; wa2 = 5'd15; wd2 = 32'hDEAD_BEEF;
      step();
      quiet(); a1 = 5'd1; a2 = 5'd15;
      step();

      // Collision on x4: port 2 wins, one-cycle conflict pulse.
      we1 = 1'b1; wa1 = 5'd4; wd1 = 32'h11;
      we2 = 1'b1; wa2 = 5'd4; wd2 = 32'h22;
      step();
      quiet(); a1 = 5'd4; a2 = 5'd4;
      step();
      step();

      // x0 is hardwired; we gating.
      we1 = 1'b1; wa1 = 5'd0; wd1 = 32'h6; a1 = 5'd0;
      step();
      quiet();
      step();
      wa1 = 5'd1; wd1 = 32'hF; a1 = 5'd1;
      step();
      step();

      // Fill, clear, drop writes during the sweep, ignored second clr.
      for (int i = 1; i < DEPTH; i++) begin
         we1 = 1'b1; wa1 = AW'(i); wd1 = $urandom | 32'h1;
         step();
      end
      quiet(); clr = 1'b1;
      step();
      for (int i = 0; i < DEPTH - 1; i++) begin
         rand_inputs(1'b0);
         clr = (i == 10);
         step();
      end
      read_all();

      // Same-cycle write/read of x7.
      we1 = 1'b1; wa1 = 5'd7; wd1 = 32'h55; a1 = 5'd7; a2 = 5'd7;
      step();
      quiet();
      step();

      // Random traffic with occasional clears and a reset during a sweep.
      for (int i = 0; i < 300; i++) begin
         rand_inputs(1'b1);
         step();
      end
      quiet(); clr = 1'b1;
      step();
      clr = 1'b0;
      for (int i = 0; i < 5; i++) step();
      do_reset();
      for (int i = 0; i < 300; i++) begin
         rand_inputs(1'b1);
         step();
      end
      // Reset mid-idle after some writes.
      quiet();
      for (int i = 0; i < 40; i++) step();
      we1 = 1'b1; wa1 = 5'd9; wd1 = 32'h1234;
      step();
      quiet();
      do_reset();
      for (int i = 0; i < DEPTH - 1; i++) step();
      read_all();

      @(negedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
